// File: rtl/perm_round_ctrl_pkg.sv
// Shared types and permutation selector codes for the permutation round controller.
package perm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } prc_state_t;

    typedef logic [127:0] block_t;

    localparam logic [1:0] SEL_PAIRSWAP = 2'b00;
    localparam logic [1:0] SEL_NIBSWAP  = 2'b01;
    localparam logic [1:0] SEL_BITREV   = 2'b10;
    localparam logic [1:0] SEL_MIX      = 2'b11;

endpackage

// File: rtl/perm_round_ctrl_if.sv
// Block input and result output channels of the round controller.
// Both channels are valid/ready: a transfer happens on the rising edge where valid and ready
// are both high; a raised valid holds, with its payload unchanged, until that edge.
interface perm_round_ctrl_if #(
    parameter int KEY_W = 8
);
    import perm_pkg::*;

    logic             in_valid;
    logic             in_ready;
    block_t           in_block;
    logic [KEY_W-1:0] in_key;
    logic             in_decrypt;
    logic             out_valid;
    logic             out_ready;
    block_t           out_block;

    modport master (
        output in_valid, in_block, in_key, in_decrypt, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, in_key, in_decrypt, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/perm_round_ctrl_key_sched.sv
// Round-key holder: latches the key string and direction, and picks the 2-bit selector
// for the current round (reverse order when decrypting).
module perm_key_sched
    import perm_pkg::*;
#(
    parameter int ROUNDS = 4,
    parameter int KEY_W  = 2 * ROUNDS,
    parameter int CNT_W  = $clog2(ROUNDS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             i_load,
    input  logic [KEY_W-1:0] i_key,
    input  logic             i_decrypt,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_round_cnt,
    output logic [1:0]       o_sel
);
    logic [KEY_W-1:0] r_key;
    logic             r_dec;
    logic [CNT_W-1:0] w_key_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_dec <= 1'b0;
        end else if (flush) begin
            r_key <= '0;
            r_dec <= 1'b0;
        end else if (i_load) begin
            r_key <= i_key;
            r_dec <= i_decrypt;
        end
    end

    // Selector is forced to pair-swap code whenever the unit is disabled.
    always_comb begin
        w_key_idx = r_dec ? (CNT_W'(ROUNDS - 1) - i_round_cnt) : i_round_cnt;
        o_sel     = SEL_PAIRSWAP;
        if (i_en) begin
            for (int r = 0; r < ROUNDS; r++) begin
                if (w_key_idx == CNT_W'(r)) o_sel = r_key[2*r +: 2];
            end
        end
    end

endmodule

// File: rtl/perm_round_ctrl.sv
// Iterative round sequencer: loops a 128-bit block through an external permutation unit
// ROUNDS times, one key pair per cycle, and returns the result under valid/ready.
module perm_round_ctrl
    import perm_pkg::*;
#(
    parameter int ROUNDS = 4,
    parameter int KEY_W  = 2 * ROUNDS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    perm_round_ctrl_if.slave            bus,
    output logic                        perm_en,
    output logic [1:0]                  perm_sel,
    output block_t                      perm_in,
    input  block_t                      perm_out,
    output logic                        busy,
    output logic [$clog2(ROUNDS+1)-1:0] round_cnt,
    output prc_state_t                  o_dbg_state
);
    localparam int CNT_W = $clog2(ROUNDS + 1);

    prc_state_t       r_state;
    prc_state_t       w_state_nxt;
    block_t           r_state_reg;
    logic [CNT_W-1:0] r_round_cnt;
    logic             w_accept;
    logic             w_last_round;

    assign w_accept     = bus.in_valid && (r_state == IDLE) && !flush;
    assign w_last_round = (r_round_cnt == CNT_W'(ROUNDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        perm_en       = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                busy         = 1'b0;
                if (w_accept) w_state_nxt = RUN;
            end
            RUN: begin
                perm_en = 1'b1;
                if (w_last_round) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort wins over both accept and delivery.
        if (flush) w_state_nxt = IDLE;
    end

    // perm_out is only captured in RUN; the unit output is undefined otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_reg <= '0;
            r_round_cnt <= '0;
        end else if (flush) begin
            r_round_cnt <= '0;
        end else if (w_accept) begin
            r_state_reg <= bus.in_block;
            r_round_cnt <= '0;
        end else if (r_state == RUN) begin
            r_state_reg <= perm_out;
            r_round_cnt <= r_round_cnt + CNT_W'(1);
        end
    end

    perm_key_sched #(
        .ROUNDS (ROUNDS),
        .KEY_W  (KEY_W),
        .CNT_W  (CNT_W)
    ) u_key_sched (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .i_load      (w_accept),
        .i_key       (bus.in_key),
        .i_decrypt   (bus.in_decrypt),
        .i_en        (perm_en),
        .i_round_cnt (r_round_cnt),
        .o_sel       (perm_sel)
    );

    assign perm_in       = r_state_reg;
    assign bus.out_block = r_state_reg;
    assign round_cnt     = r_round_cnt;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Bench for perm_round_ctrl: a ROUNDS=4 and a ROUNDS=1 instance, each looped through a
// behavioural permutation unit, driven from a vector table plus multi-cycle sequences.
module tb_perm_round_ctrl;
    import perm_pkg::*;

    localparam block_t FLOAT = {8{16'hDEAD}};
    localparam int     NV    = 14;

    typedef struct {
        int         dut;
        logic [7:0] byte_in;
        logic [7:0] key;
        logic       dec;
        logic [7:0] byte_exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc_cnt = 0;
    int         sel_idle_err = 0;
    logic [127:0] exp4_q[$];
    logic [127:0] exp1_q[$];
    logic [1:0]   sel4_log[$];

    logic       perm_en4, perm_en1, busy4, busy1;
    logic [1:0] perm_sel4, perm_sel1;
    block_t     perm_in4, perm_in1, perm_out4, perm_out1;
    logic [2:0] round_cnt4;
    logic [0:0] round_cnt1;
    prc_state_t state4, state1;

    perm_round_ctrl_if #(.KEY_W(8)) bus4 ();
    perm_round_ctrl_if #(.KEY_W(2)) bus1 ();

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;

    perm_round_ctrl #(.ROUNDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus4),
        .perm_en(perm_en4), .perm_sel(perm_sel4), .perm_in(perm_in4), .perm_out(perm_out4),
        .busy(busy4), .round_cnt(round_cnt4), .o_dbg_state(state4)
    );

    perm_round_ctrl #(.ROUNDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus1),
        .perm_en(perm_en1), .perm_sel(perm_sel1), .perm_in(perm_in1), .perm_out(perm_out1),
        .busy(busy1), .round_cnt(round_cnt1), .o_dbg_state(state1)
    );

    // Per-byte involutions: pair swap, nibble swap, bit reverse, bit i <-> bit (8-i) mod 8.
    function automatic logic [7:0] perm_byte(input logic [1:0] sel, input logic [7:0] b);
        logic [7:0] r;
        r = '0;
        case (sel)
            2'b00:   for (int i = 0; i < 8; i++) r[i ^ 1] = b[i];
            2'b01:   r = {b[3:0], b[7:4]};
            2'b10:   for (int i = 0; i < 8; i++) r[7 - i] = b[i];
            default: for (int i = 0; i < 8; i++) r[(8 - i) % 8] = b[i];
        endcase
        return r;
    endfunction

    function automatic block_t perm_blk(input logic [1:0] sel, input block_t x);
        block_t r;
        r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = perm_byte(sel, x[8*i +: 8]);
        return r;
    endfunction

    function automatic block_t fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    always_comb perm_out4 = perm_en4 ? perm_blk(perm_sel4, perm_in4) : FLOAT;
    always_comb perm_out1 = perm_en1 ? perm_blk(perm_sel1, perm_in1) : FLOAT;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every delivered result must match the head of its expected queue.
    always @(negedge clk) begin
        if (rst_n && bus4.out_valid && bus4.out_ready) begin
            if (exp4_q.size() == 0) check("unexpected_out4", bus4.out_block, 128'h0);
            else check("out_block4", bus4.out_block, exp4_q.pop_front());
        end
        if (rst_n && bus1.out_valid && bus1.out_ready) begin
            if (exp1_q.size() == 0) check("unexpected_out1", bus1.out_block, 128'h0);
            else check("out_block1", bus1.out_block, exp1_q.pop_front());
        end
        if (perm_en4) sel4_log.push_back(perm_sel4);
        else if (perm_sel4 != 2'b00) sel_idle_err++;
        if (!perm_en1 && perm_sel1 != 2'b00) sel_idle_err++;
    end

    task automatic drive_in(input int d, input logic v, input block_t b, input logic [7:0] k,
                            input logic dc);
        if (d == 1) begin
            bus1.in_valid = v; bus1.in_block = b; bus1.in_key = k[1:0]; bus1.in_decrypt = dc;
        end else begin
            bus4.in_valid = v; bus4.in_block = b; bus4.in_key = k; bus4.in_decrypt = dc;
        end
    endtask

    task automatic drive_idle(input int d);
        block_t g;
        g = {$urandom(), $urandom(), $urandom(), $urandom()};
        drive_in(d, 1'b0, g, 8'($urandom()), 1'($urandom()));
    endtask

    // Offers one block, returns cycles from the accept cycle to out_valid and the accept cycle.
    task automatic send(input int d, input block_t b, input logic [7:0] k, input logic dc,
                        output int lat, output int acc);
        int guard;
        @(negedge clk);
        drive_in(d, 1'b1, b, k, dc);
        guard = 0;
        while (!((d == 1) ? bus1.in_ready : bus4.in_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        acc = cyc_cnt;
        @(negedge clk);
        drive_idle(d);
        lat = 1;
        while (!((d == 1) ? bus1.out_valid : bus4.out_valid) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    vec_t       vecs [NV];
    int         lat, acc, prev_acc, w;
    block_t     pt, ct;
    logic [7:0] seq;
    logic       seen;

    initial begin
        vecs[0]  = '{4, 8'h0F, 8'h01, 1'b0, 8'hF0};
        vecs[1]  = '{4, 8'h0F, 8'h01, 1'b1, 8'hF0};
        vecs[2]  = '{4, 8'h01, 8'h02, 1'b0, 8'h40};
        vecs[3]  = '{4, 8'h01, 8'h02, 1'b1, 8'h40};
        vecs[4]  = '{4, 8'h12, 8'hE4, 1'b0, 8'h24};
        vecs[5]  = '{4, 8'h24, 8'hE4, 1'b1, 8'h12};
        vecs[6]  = '{4, 8'hA5, 8'h55, 1'b0, 8'hA5};
        vecs[7]  = '{4, 8'h02, 8'h03, 1'b0, 8'h40};
        vecs[8]  = '{4, 8'h02, 8'h03, 1'b1, 8'h01};
        vecs[9]  = '{4, 8'h01, 8'h20, 1'b0, 8'h40};
        vecs[10] = '{1, 8'h01, 8'h02, 1'b0, 8'h80};
        vecs[11] = '{1, 8'h01, 8'h03, 1'b0, 8'h01};
        vecs[12] = '{1, 8'h02, 8'h03, 1'b0, 8'h80};
        vecs[13] = '{1, 8'h01, 8'h02, 1'b1, 8'h80};

        drive_idle(4);
        drive_idle(1);
        bus4.out_ready = 1'b1;
        bus1.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_perm_en", perm_en4, 1'b0);
        check("rst_perm_sel", perm_sel4, 2'b00);
        check("rst_out_valid", bus4.out_valid, 1'b0);
        check("rst_busy", busy4, 1'b0);
        check("rst_round_cnt", round_cnt4, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus4.in_ready, 1'b1);

        // Vector table
        prev_acc = 0;
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].dut == 1) exp1_q.push_back(fill(vecs[i].byte_exp));
            else                  exp4_q.push_back(fill(vecs[i].byte_exp));
            send(vecs[i].dut, fill(vecs[i].byte_in), vecs[i].key, vecs[i].dec, lat, acc);
            check($sformatf("v%0d_latency", i), lat, vecs[i].dut + 1);
            if (i > 0 && vecs[i].dut == vecs[i-1].dut)
                check($sformatf("v%0d_interval", i), acc - prev_acc, vecs[i].dut + 2);
            prev_acc = acc;
        end
        check("r1_round_cnt_sat", round_cnt1, 1'b1);
        check("r1_state_done", state1, DONE);

        // Encrypt/decrypt round trip with key B4
        pt = 128'h0123456789ABCDEFFEDCBA9876543210;
        ct = perm_blk(2'b10, perm_blk(2'b11, perm_blk(2'b01, perm_blk(2'b00, pt))));
        sel4_log.delete();
        exp4_q.push_back(ct);
        send(4, pt, 8'hB4, 1'b0, lat, acc);
        check("enc_sel_count", sel4_log.size(), 4);
        if (sel4_log.size() == 4) begin
            seq = {sel4_log[0], sel4_log[1], sel4_log[2], sel4_log[3]};
            check("enc_sel_seq", seq, 8'b00_01_11_10);
        end
        sel4_log.delete();
        exp4_q.push_back(pt);
        send(4, ct, 8'hB4, 1'b1, lat, acc);
        check("dec_sel_count", sel4_log.size(), 4);
        if (sel4_log.size() == 4) begin
            seq = {sel4_log[0], sel4_log[1], sel4_log[2], sel4_log[3]};
            check("dec_sel_seq", seq, 8'b10_11_01_00);
        end

        // Back-pressure: result held 7 cycles, new offer waits for delivery
        @(negedge clk);
        bus4.out_ready = 1'b0;
        exp4_q.push_back(fill(8'hF0));
        send(4, fill(8'h0F), 8'h01, 1'b0, lat, acc);
        drive_in(4, 1'b1, fill(8'h12), 8'hE4, 1'b0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("bp_out_block", bus4.out_block, fill(8'hF0));
            check("bp_out_valid", bus4.out_valid, 1'b1);
            check("bp_in_ready", bus4.in_ready, 1'b0);
        end
        check("bp_round_cnt_sat", round_cnt4, 3'd4);
        exp4_q.push_back(fill(8'h24));
        @(posedge clk);
        #1 bus4.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after_ready", bus4.in_ready, 1'b1);
        @(negedge clk);
        check("bp_accepted_next", state4, RUN);
        drive_idle(4);
        w = 0;
        while (!bus4.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp_second_done", bus4.out_valid, 1'b1);

        // Flush in the second RUN cycle with a new offer pending
        @(negedge clk);
        drive_in(4, 1'b1, fill(8'h77), 8'h1B, 1'b0);
        @(negedge clk);
        drive_idle(4);
        @(negedge clk);
        flush = 1'b1;
        drive_in(4, 1'b1, fill(8'h12), 8'hE4, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        drive_idle(4);
        check("flush_state", state4, IDLE);
        check("flush_round_cnt", round_cnt4, 3'd0);
        check("flush_out_valid", bus4.out_valid, 1'b0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            seen = seen | bus4.out_valid;
        end
        check("flush_no_result", seen, 1'b0);

        // Flush in IDLE beats an offered block
        flush = 1'b1;
        drive_in(4, 1'b1, fill(8'h12), 8'hE4, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        drive_idle(4);
        check("flush_idle_no_accept", busy4, 1'b0);

        // Asynchronous reset mid-RUN
        @(negedge clk);
        drive_in(4, 1'b1, fill(8'h3C), 8'hE4, 1'b0);
        @(negedge clk);
        drive_idle(4);
        @(negedge clk);
        check("pre_rst_run", perm_en4, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_perm_en", perm_en4, 1'b0);
        check("arst_perm_sel", perm_sel4, 2'b00);
        check("arst_out_valid", bus4.out_valid, 1'b0);
        check("arst_round_cnt", round_cnt4, 3'd0);
        check("arst_state_reg", perm_in4, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", bus4.in_ready, 1'b1);
        repeat (8) @(negedge clk);
        check("arst_no_result", bus4.out_valid, 1'b0);

        check("sel_zero_when_idle", sel_idle_err, 0);
        check("exp4_drained", exp4_q.size(), 0);
        check("exp1_drained", exp1_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
